// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches over a req/ready handshake,
// and stalls the control unit while a fetch is outstanding.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [33:0] control_word,
    input  logic [63:0] constant,
    input  logic [63:0] a_bus,
    output logic [63:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] I,
    output logic [63:0] pc,
    output logic        stall,
    output logic        fault
);

    typedef enum logic { S_IDLE, S_WAIT } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        fault_q, fault_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic [1:0]  ps;
    logic        pcsel, il;
    logic [63:0] sel, next_pc;
    logic        cw_unused;

    assign ps        = control_word[30:29];
    assign pcsel     = control_word[28];
    assign il        = control_word[26];
    assign cw_unused = ^{control_word[33:31], control_word[27], control_word[25:0]};

    assign sel = pcsel ? constant : a_bus;

    // PS=11: PC already advanced past the branch, so back up one word first.
    always_comb begin
        next_pc = pc_q;
        case (ps)
            2'b00: next_pc = pc_q;
            2'b01: next_pc = pc_q + 64'd4;
            2'b10: next_pc = sel;
            2'b11: next_pc = pc_q - 64'd4 + (sel << 2);
            default: next_pc = pc_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        fault_d    = fault_q;
        wait_cnt_d = wait_cnt_q;
        imem_req   = 1'b0;
        stall      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!il) begin
                    pc_d = next_pc;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_d = imem_rdata;
                        pc_d = next_pc;
                    end else begin
                        stall      = 1'b1;
                        wait_cnt_d = 8'd1;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    pc_d    = next_pc;
                    state_d = S_IDLE;
                end else if (wait_cnt_q == 8'(MAX_WAIT)) begin
                    // Timeout: abandon the fetch and let the control unit run on a zero IR.
                    fault_d = 1'b1;
                    ir_d    = 32'h0;
                    state_d = S_IDLE;
                end else begin
                    stall      = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (reset) begin
            imem_req = 1'b0;
            stall    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0;
            fault_q    <= 1'b0;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            fault_q    <= fault_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign I         = ir_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with hand-computed expectations.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [33:0] control_word;
    logic [63:0] constant;
    logic [63:0] a_bus;
    logic [63:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] I;
    logic [63:0] pc;
    logic        stall;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch_unit #(.RESET_PC(64'h0), .MAX_WAIT(15)) dut (
        .clock(clock), .reset(reset), .control_word(control_word),
        .constant(constant), .a_bus(a_bus), .imem_addr(imem_addr),
        .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .I(I), .pc(pc), .stall(stall), .fault(fault)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] cw(input logic [1:0] ps, input logic pcsel, input logic il);
        logic [33:0] w;
        w = '0;
        w[30:29] = ps;
        w[28]    = pcsel;
        w[26]    = il;
        return w;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; control_word = '0; constant = '0; a_bus = '0;
        imem_rdata = '0; imem_ready = 1'b0;
        tick(); tick();
        #1;
        chk("rst_pc", pc, 64'h0);
        chk("rst_I", {32'h0, I}, 64'h0);
        chk("rst_fault", {63'h0, fault}, 64'h0);
        chk("rst_req", {63'h0, imem_req}, 64'h0);
        chk("rst_stall", {63'h0, stall}, 64'h0);
        reset = 1'b0;

        // 1: zero-wait fetch
        control_word = cw(2'b01, 1'b0, 1'b1);
        imem_ready = 1'b1; imem_rdata = 32'h8B020020;
        #1;
        chk("t1_req", {63'h0, imem_req}, 64'h1);
        chk("t1_stall", {63'h0, stall}, 64'h0);
        tick();
        chk("t1_I", {32'h0, I}, 64'h8B020020);
        chk("t1_pc", pc, 64'h4);
        control_word = cw(2'b00, 1'b0, 1'b0); imem_ready = 1'b0;

        // 2: three wait states, from pc=0
        reset = 1'b1; tick(); reset = 1'b0;
        control_word = cw(2'b01, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            imem_ready = (k == 3);
            imem_rdata = (k == 3) ? 32'h12345678 : 32'hDEADBEEF;
            #1;
            chk($sformatf("t2_req%0d", k), {63'h0, imem_req}, 64'h1);
            chk($sformatf("t2_addr%0d", k), imem_addr, 64'h0);
            chk($sformatf("t2_stall%0d", k), {63'h0, stall}, (k < 3) ? 64'h1 : 64'h0);
            tick();
            chk($sformatf("t2_pc%0d", k), pc, (k < 3) ? 64'h0 : 64'h4);
            chk($sformatf("t2_I%0d", k), {32'h0, I}, (k < 3) ? 64'h0 : 64'h12345678);
        end
        control_word = cw(2'b00, 1'b0, 1'b0); imem_ready = 1'b0;

        // 3: relative branch
        control_word = cw(2'b10, 1'b0, 1'b0); a_bus = 64'h100; tick();
        chk("t3_load", pc, 64'h100);
        control_word = cw(2'b11, 1'b1, 1'b0); constant = -64'sd2; tick();
        chk("t3_back", pc, 64'hF4);
        control_word = cw(2'b10, 1'b0, 1'b0); a_bus = 64'h100; tick();
        control_word = cw(2'b11, 1'b1, 1'b0); constant = 64'd1; tick();
        chk("t3_fwd", pc, 64'h100);

        // 4: register jump then hold; ready with no request is ignored
        control_word = cw(2'b10, 1'b0, 1'b0); a_bus = 64'h2000; tick();
        chk("t4_jump", pc, 64'h2000);
        control_word = cw(2'b00, 1'b0, 1'b0);
        imem_ready = 1'b1; imem_rdata = 32'hFFFFFFFF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t4_noreq%0d", k), {63'h0, imem_req}, 64'h0);
            tick();
            chk($sformatf("t4_hold%0d", k), pc, 64'h2000);
        end
        chk("t4_I", {32'h0, I}, 64'h12345678);
        imem_ready = 1'b0;

        // 5: timeout
        control_word = cw(2'b01, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            #1;
            chk($sformatf("t5_stall%0d", k), {63'h0, stall}, (k < 15) ? 64'h1 : 64'h0);
            chk($sformatf("t5_req%0d", k), {63'h0, imem_req}, 64'h1);
            if (k < 15) chk($sformatf("t5_nofault%0d", k), {63'h0, fault}, 64'h0);
            tick();
        end
        chk("t5_fault", {63'h0, fault}, 64'h1);
        chk("t5_I", {32'h0, I}, 64'h0);
        chk("t5_pc", pc, 64'h2000);
        control_word = cw(2'b00, 1'b0, 1'b0);
        #1;
        chk("t5_stall_after", {63'h0, stall}, 64'h0);
        tick();
        chk("t5_sticky", {63'h0, fault}, 64'h1);

        // 6: reset in the second WAIT cycle with ready high
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_fault_clr", {63'h0, fault}, 64'h0);
        control_word = cw(2'b01, 1'b0, 1'b1);
        imem_ready = 1'b1; imem_rdata = 32'h11111111; tick();
        chk("t6_pre_I", {32'h0, I}, 64'h11111111);
        chk("t6_pre_pc", pc, 64'h4);
        imem_ready = 1'b0; tick();
        tick();
        imem_ready = 1'b1; imem_rdata = 32'hAAAAAAAA; reset = 1'b1;
        tick();
        chk("t6_pc", pc, 64'h0);
        chk("t6_I", {32'h0, I}, 64'h0);
        chk("t6_req", {63'h0, imem_req}, 64'h0);
        reset = 1'b0; control_word = cw(2'b00, 1'b0, 1'b0); imem_ready = 1'b0;
        tick();
        chk("t6_idle_req", {63'h0, imem_req}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
